// File: rtl/izigzag_blk_ctl.sv
// ---------------------------------------------------------------------------
// izigzag_blk_ctl
//
// Tags a stream of 16-bit coefficient tokens with their zigzag position inside
// an 8x8 block (row, column, last-of-block). There is one output register
// stage with valid/backpressure handshaking, so a full-rate stream passes
// through at one token per cycle. An end-of-stream token is forwarded and then
// parks the block in DONE until reset.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-low
//   ruS_d      : input token data
//   ruS_v      : input token valid
//   ruS_e      : input end-of-stream marker (qualified by ruS_v)
//   ruS_b      : backpressure to producer (1 = hold the token)
//   chuO_d     : output token data (registered)
//   chuO_row   : zigzag row of the output token
//   chuO_col   : zigzag column of the output token (channel select A..H)
//   chuO_last  : output token is index 63 of its block
//   chuO_v     : output token valid
//   chuO_e     : output end-of-stream marker (qualified by chuO_v)
//   chuO_b     : backpressure from consumer
//   blk_cnt    : number of completed 64-token blocks (wraps)
//   short_blk  : sticky, end-of-stream arrived in the middle of a block
// ---------------------------------------------------------------------------
module izigzag_blk_ctl (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ruS_d,
    input  logic        ruS_v,
    input  logic        ruS_e,
    output logic        ruS_b,
    output logic [15:0] chuO_d,
    output logic [2:0]  chuO_row,
    output logic [2:0]  chuO_col,
    output logic        chuO_last,
    output logic        chuO_v,
    output logic        chuO_e,
    input  logic        chuO_b,
    output logic [15:0] blk_cnt,
    output logic        short_blk
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t     state;

    // Walker: current position in the zigzag scan and its direction
    // (0 = moving up-right, 1 = moving down-left).
    logic [2:0] walkRow;
    logic [2:0] walkCol;
    logic       walkDir;
    logic [5:0] walkIdx;

    logic [2:0] nextRow;
    logic [2:0] nextCol;
    logic       nextDir;
    logic       accept;

    // The register can take a token when empty or when its current token
    // leaves this cycle; after end-of-stream nothing more is taken.
    assign ruS_b  = (state == DONE) || (chuO_v && chuO_b);
    assign accept = ruS_v && !ruS_b;

    // Zigzag step. At an edge of the block the walker slides one place along
    // that edge and turns around.
    always_comb begin
        nextRow = walkRow;
        nextCol = walkCol;
        nextDir = walkDir;
        if (!walkDir) begin
            if (walkCol == 3'd7) begin
                nextRow = walkRow + 3'd1;
                nextDir = 1'b1;
            end else if (walkRow == 3'd0) begin
                nextCol = walkCol + 3'd1;
                nextDir = 1'b1;
            end else begin
                nextRow = walkRow - 3'd1;
                nextCol = walkCol + 3'd1;
            end
        end else begin
            if (walkRow == 3'd7) begin
                nextCol = walkCol + 3'd1;
                nextDir = 1'b0;
            end else if (walkCol == 3'd0) begin
                nextRow = walkRow + 3'd1;
                nextDir = 1'b0;
            end else begin
                nextRow = walkRow + 3'd1;
                nextCol = walkCol - 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            walkRow   <= 3'd0;
            walkCol   <= 3'd0;
            walkDir   <= 1'b0;
            walkIdx   <= 6'd0;
            chuO_d    <= 16'd0;
            chuO_row  <= 3'd0;
            chuO_col  <= 3'd0;
            chuO_last <= 1'b0;
            chuO_v    <= 1'b0;
            chuO_e    <= 1'b0;
            blk_cnt   <= 16'd0;
            short_blk <= 1'b0;
        end else begin
            if (accept) begin
                chuO_v <= 1'b1;
                chuO_d <= ruS_d;
                if (ruS_e) begin
                    // End-of-stream: forwarded untagged, walker rewound.
                    chuO_e    <= 1'b1;
                    chuO_row  <= 3'd0;
                    chuO_col  <= 3'd0;
                    chuO_last <= 1'b0;
                    if (walkIdx != 6'd0) begin
                        short_blk <= 1'b1;
                    end
                    walkRow <= 3'd0;
                    walkCol <= 3'd0;
                    walkDir <= 1'b0;
                    walkIdx <= 6'd0;
                    state   <= DONE;
                end else begin
                    chuO_e    <= 1'b0;
                    chuO_row  <= walkRow;
                    chuO_col  <= walkCol;
                    chuO_last <= (walkIdx == 6'd63);
                    if (walkIdx == 6'd63) begin
                        walkRow <= 3'd0;
                        walkCol <= 3'd0;
                        walkDir <= 1'b0;
                        walkIdx <= 6'd0;
                        blk_cnt <= blk_cnt + 16'd1;
                    end else begin
                        walkRow <= nextRow;
                        walkCol <= nextCol;
                        walkDir <= nextDir;
                        walkIdx <= walkIdx + 6'd1;
                    end
                end
            end else if (!chuO_b) begin
                // Token consumed with nothing to replace it; payload is held.
                chuO_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_izigzag_blk_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for izigzag_blk_ctl. A reference model (zigzag order built from
// anti-diagonals, plus a one-entry output register) predicts every output on
// every cycle; directed tables and sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_izigzag_blk_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ruS_d = 16'd0;
    logic        ruS_v = 1'b0;
    logic        ruS_e = 1'b0;
    logic        ruS_b;
    logic [15:0] chuO_d;
    logic [2:0]  chuO_row;
    logic [2:0]  chuO_col;
    logic        chuO_last;
    logic        chuO_v;
    logic        chuO_e;
    logic        chuO_b = 1'b0;
    logic [15:0] blk_cnt;
    logic        short_blk;

    izigzag_blk_ctl dut (
        .clock     (clock),
        .reset     (reset),
        .ruS_d     (ruS_d),
        .ruS_v     (ruS_v),
        .ruS_e     (ruS_e),
        .ruS_b     (ruS_b),
        .chuO_d    (chuO_d),
        .chuO_row  (chuO_row),
        .chuO_col  (chuO_col),
        .chuO_last (chuO_last),
        .chuO_v    (chuO_v),
        .chuO_e    (chuO_e),
        .chuO_b    (chuO_b),
        .blk_cnt   (blk_cnt),
        .short_blk (short_blk)
    );

    always #5 clock = ~clock;

    int nAssert = 0;
    int nFail   = 0;

    // Zigzag order: anti-diagonal s = row+col; odd diagonals run top to
    // bottom, even diagonals bottom to top.
    int zzRow[64];
    int zzCol[64];

    // Reference model state
    int          mIdx;
    int          mBlk;
    bit          mShort;
    bit          mDone;
    bit          mV;
    bit          mE;
    bit          mLast;
    int          mRow;
    int          mCol;
    logic [15:0] mD;
    int          nTok;

    typedef struct {
        logic        v;
        logic        e;
        logic [15:0] d;
        logic        b;
        logic        expV;
        logic [2:0]  expRow;
        logic [2:0]  expCol;
        logic        expLast;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic buildZigzag();
        int k;
        k = 0;
        for (int s = 0; s <= 14; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin
                    zzRow[k] = r; zzCol[k] = s - r; k++;
                end
            end else begin
                for (int r = hi; r >= lo; r--) begin
                    zzRow[k] = r; zzCol[k] = s - r; k++;
                end
            end
        end
    endtask

    task automatic modelReset();
        mIdx = 0; mBlk = 0; mShort = 0; mDone = 0;
        mV = 0; mE = 0; mLast = 0; mRow = 0; mCol = 0; mD = 16'd0;
    endtask

    task automatic compareAll();
        check("chuO_v", chuO_v, mV);
        if (mV) begin
            check("chuO_d", chuO_d, mD);
            check("chuO_row", chuO_row, mRow);
            check("chuO_col", chuO_col, mCol);
            check("chuO_last", chuO_last, mLast);
            check("chuO_e", chuO_e, mE);
        end
        check("blk_cnt", blk_cnt, mBlk[15:0]);
        check("short_blk", short_blk, mShort);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic v, input logic e, input logic [15:0] d,
                         input logic b, output bit acc);
        bit expB;
        ruS_v = v; ruS_e = e; ruS_d = d; chuO_b = b;
        #1;
        expB = mDone || (mV && b);
        check("ruS_b", ruS_b, expB);
        acc = v && !expB;
        @(posedge clock);
        #1;
        if (acc) begin
            mV = 1; mD = d;
            if (e) begin
                mE = 1; mRow = 0; mCol = 0; mLast = 0;
                if (mIdx != 0) mShort = 1;
                mIdx = 0; mDone = 1;
            end else begin
                mE = 0; mRow = zzRow[mIdx]; mCol = zzCol[mIdx];
                mLast = (mIdx == 63);
                if (mIdx == 63) begin
                    mIdx = 0; mBlk = (mBlk + 1) % 65536;
                end else begin
                    mIdx++;
                end
            end
            nTok++;
            $display("tok %0d d=%h row=%0d col=%0d last=%0d e=%0d blk=%0d",
                     nTok, chuO_d, chuO_row, chuO_col, chuO_last, chuO_e, blk_cnt);
        end else if (!b) begin
            mV = 0;
        end
        compareAll();
    endtask

    // Reset pulse placed mid-cycle; outputs must clear while reset is low.
    task automatic doReset();
        ruS_v = 0; ruS_e = 0; ruS_d = 16'd0; chuO_b = 1'b0;
        reset = 1'b0;
        #2;
        check("rst_chuO_v", chuO_v, 1'b0);
        check("rst_chuO_e", chuO_e, 1'b0);
        check("rst_chuO_last", chuO_last, 1'b0);
        check("rst_chuO_d", chuO_d, 16'd0);
        check("rst_chuO_row", chuO_row, 3'd0);
        check("rst_chuO_col", chuO_col, 3'd0);
        check("rst_blk_cnt", blk_cnt, 16'd0);
        check("rst_short_blk", short_blk, 1'b0);
        modelReset();
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ruS_b", ruS_b, 1'b0);
    endtask

    initial begin
        bit acc;
        int r036Row[4];
        int r036Col[4];
        int cnt;
        r036Row = '{5, 6, 7, 7};
        r036Col = '{7, 7, 6, 7};
        nTok = 0;
        buildZigzag();
        doReset();

        // First tokens of a block with a free-running consumer, then idle.
        tbl[0] = '{1'b1, 1'b0, 16'h1000, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h1001, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h1002, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h1003, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h1004, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h1005, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h1006, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'hdead, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].b, acc);
            check($sformatf("tbl%0d_v", i), chuO_v, tbl[i].expV);
            if (tbl[i].expV) begin
                check($sformatf("tbl%0d_d", i), chuO_d, tbl[i].d);
                check($sformatf("tbl%0d_row", i), chuO_row, tbl[i].expRow);
                check($sformatf("tbl%0d_col", i), chuO_col, tbl[i].expCol);
                check($sformatf("tbl%0d_last", i), chuO_last, tbl[i].expLast);
            end
        end

        // Full block back-to-back, then the first token of the next block.
        doReset();
        for (int k = 0; k <= 64; k++) begin
            cycle(1'b1, 1'b0, 16'(k), 1'b0, acc);
            check("blk_last", chuO_last, (k == 63));
            if (k >= 60 && k <= 63) begin
                check("blk_tail_row", chuO_row, r036Row[k-60]);
                check("blk_tail_col", chuO_col, r036Col[k-60]);
            end
            if (k == 64) begin
                check("blk_next_row", chuO_row, 3'd0);
                check("blk_next_col", chuO_col, 3'd0);
                check("blk_cnt_one", blk_cnt, 16'd1);
            end
        end

        // Consumer stall for 5 cycles with the register full.
        doReset();
        cycle(1'b1, 1'b0, 16'h2000, 1'b1, acc);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 16'h2100 + 16'(k), 1'b1, acc);
            check("stall_ruS_b", ruS_b, 1'b1);
            check("stall_d", chuO_d, 16'h2000);
        end
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 16'h2200 + 16'(k), 1'b0, acc);
            if (acc) cnt++;
        end
        check("stall_rate", cnt, 6);
        check("stall_next_d", chuO_d, 16'h2205);

        // End-of-stream after 10 data tokens.
        doReset();
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 16'h3000 + 16'(k), 1'b0, acc);
        cycle(1'b1, 1'b1, 16'h3eee, 1'b0, acc);
        check("eos_e", chuO_e, 1'b1);
        check("eos_v", chuO_v, 1'b1);
        check("eos_short", short_blk, 1'b1);
        check("eos_blk", blk_cnt, 16'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 16'h3f00, 1'b0, acc);
            check("eos_ruS_b", ruS_b, 1'b1);
            check("eos_drained", chuO_v, 1'b0);
        end

        // End-of-stream exactly on a block boundary.
        doReset();
        for (int k = 0; k < 128; k++) cycle(1'b1, 1'b0, 16'h4000 + 16'(k), 1'b0, acc);
        cycle(1'b1, 1'b1, 16'h4eee, 1'b0, acc);
        check("eos128_short", short_blk, 1'b0);
        check("eos128_blk", blk_cnt, 16'd2);
        cycle(1'b1, 1'b0, 16'h4f00, 1'b0, acc);
        check("eos128_done", ruS_b, 1'b1);

        // Reset pulse mid-block with the output stalled.
        doReset();
        for (int k = 0; k < 30; k++) cycle(1'b1, 1'b0, 16'h5000 + 16'(k), 1'b0, acc);
        cycle(1'b1, 1'b0, 16'h5100, 1'b1, acc);
        cycle(1'b1, 1'b0, 16'h5101, 1'b1, acc);
        check("rstmid_full", chuO_v, 1'b1);
        doReset();
        cycle(1'b1, 1'b0, 16'h5200, 1'b0, acc);
        check("rstmid_row", chuO_row, 3'd0);
        check("rstmid_col", chuO_col, 3'd0);
        check("rstmid_blk", blk_cnt, 16'd0);

        // Randomised traffic against the model.
        for (int run = 0; run < 2; run++) begin
            doReset();
            for (int c = 0; c < 1500; c++) begin
                logic v;
                logic e;
                logic b;
                v = ($urandom_range(9) < 7);
                b = ($urandom_range(9) < 3);
                e = v && (c > 200) && ($urandom_range(399) == 0);
                cycle(v, e, 16'($urandom), b, acc);
            end
            cycle(1'b1, 1'b1, 16'hbeef, 1'b0, acc);
            cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
            cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
